// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states, default bus widths and a
// helper for sizing counters. Also consumed by the APB RAM slave.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_t;

    // Bits needed to hold 0..limit; never narrower than one bit so a
    // disabled (zero) limit still yields a legal vector.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response handshake plus APB bus signals of the master bridge.
// "master" is the bridge's view; "slave" is the view of whatever sits
// around it (command source, response sink and APB completer).
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
) ();

    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB bus
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter for the ACCESS phase. "expired" flags the
// last wait cycle a transfer may spend before being forcibly terminated.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up and stick at the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero limit disables the timeout entirely.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            assign expired = (count_q == LAST);
        end else begin : g_timeout_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: accepts one command at a time, runs SETUP/ACCESS on the
// APB bus and returns read data / error status on a response channel.
// Every output is driven straight from a flop.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_master_bridge_if.master bus
);

    apb_master_state_t     state_q,       state_d;
    logic                  cmd_ready_q,   cmd_ready_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;

    logic cmd_accept;
    logic wait_clear;
    logic wait_enable;
    logic wait_expired;

    assign cmd_accept  = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
    // Counter restarts when a command is taken, so it reads 0 in SETUP.
    assign wait_clear  = cmd_accept;
    assign wait_enable = (state_q == ACCESS) && !bus.PREADY;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clear   (wait_clear),
        .enable  (wait_enable),
        .expired (wait_expired)
    );

    // Next-state and next-output decode for the transfer FSM.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        paddr_d       = paddr_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                if (cmd_accept) begin
                    paddr_d     = bus.cmd_addr;
                    pwrite_d    = bus.cmd_write;
                    // Reads put a clean zero on PWDATA.
                    pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
                    psel_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                // PREADY is checked first: a completion on the timeout
                // edge is still a normal completion.
                if (bus.PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (wait_expired) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus and drops any
    // transfer in flight.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            paddr_q       <= paddr_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB RAM slave with programmable
// wait states, a transaction-level reference model checked every cycle,
// and directed plus randomized commands.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int TO        = 4;
    localparam int MEM_WORDS = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- APB RAM slave (environment) ----------------
    int          cfg_waits = 0;
    bit          cfg_stall = 1'b0;
    logic [31:0] slv_mem [MEM_WORDS] = '{default: 32'h0};
    int          slv_left = 0;

    always @(negedge clk) begin
        if (!(bus.PSEL && bus.PENABLE)) begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = $urandom;
            if (bus.PSEL) slv_left = cfg_waits;
        end else if (cfg_stall || slv_left > 0) begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'($urandom);
            bus.PRDATA  = $urandom;
            if (slv_left > 0) slv_left--;
        end else begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = (bus.PADDR >= MEM_WORDS);
            if (bus.PADDR >= MEM_WORDS) bus.PRDATA = 32'h0;
            else if (bus.PWRITE)        bus.PRDATA = $urandom;
            else                        bus.PRDATA = slv_mem[bus.PADDR[4:0]];
        end
    end

    always @(posedge clk) begin
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && (bus.PADDR < MEM_WORDS))
            slv_mem[bus.PADDR[4:0]] <= bus.PWDATA;
    end

    // ---------------- Reference model + per-cycle compare ----------------
    logic [31:0] ref_mem [MEM_WORDS] = '{default: 32'h0};
    bit          m_busy = 0, m_cmd_ready = 0, m_in_reset = 1;
    int          m_d = 0, m_len = 0;
    logic [31:0] m_paddr = 0, m_pwdata = 0, m_rdata = 0;
    bit          m_pwrite = 0, m_err = 0, m_to = 0;

    always begin : model_and_compare
        bit e_psel, e_pen, e_rv;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_cmd_ready = 0; m_in_reset = 1;
            m_paddr = 0; m_pwrite = 0; m_pwdata = 0;
            m_rdata = 0; m_err = 0; m_to = 0;
        end else begin
            m_in_reset = 0;
            if (!m_busy) begin
                if (bus.cmd_valid && m_cmd_ready) begin
                    m_busy      = 1;
                    m_d         = 0;
                    m_cmd_ready = 0;
                    m_paddr     = bus.cmd_addr;
                    m_pwrite    = bus.cmd_write;
                    m_pwdata    = bus.cmd_write ? bus.cmd_wdata : 32'h0;
                    m_to        = cfg_stall || (cfg_waits >= TO);
                    m_len       = m_to ? TO : cfg_waits + 1;
                    m_err       = m_to || (bus.cmd_addr >= MEM_WORDS);
                    m_rdata     = (m_err || m_pwrite) ? 32'h0 : ref_mem[bus.cmd_addr[4:0]];
                end else begin
                    m_cmd_ready = 1;
                end
            end else if (m_d >= m_len + 2 && bus.rsp_ready) begin
                m_busy      = 0;
                m_cmd_ready = 1;
            end
            if (m_busy) begin
                m_d++;
                if (m_d == m_len + 2 && m_pwrite && !m_err) ref_mem[m_paddr[4:0]] = m_pwdata;
            end
        end

        @(negedge clk);
        if (!m_busy)               begin e_psel = 0; e_pen = 0; e_rv = 0; end
        else if (m_d == 1)         begin e_psel = 1; e_pen = 0; e_rv = 0; end
        else if (m_d <= m_len + 1) begin e_psel = 1; e_pen = 1; e_rv = 0; end
        else                       begin e_psel = 0; e_pen = 0; e_rv = 1; end
        chk("ctrl{psel,penable,rsp_valid,cmd_ready}",
            {60'h0, bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready},
            {60'h0, e_psel, e_pen, e_rv, (m_busy ? 1'b0 : m_cmd_ready)});
        chk("paddr",  {32'h0, bus.PADDR},  {32'h0, m_paddr});
        chk("pwrite", {63'h0, bus.PWRITE}, {63'h0, m_pwrite});
        chk("pwdata", {32'h0, bus.PWDATA}, {32'h0, m_pwdata});
        if (m_in_reset)
            chk("rsp_in_reset", {30'h0, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, 64'h0);
        else if (e_rv)
            chk("rsp{rdata,err,timeout}", {30'h0, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
                {30'h0, m_rdata, m_err, m_to});
    end

    // ---------------- Driver ----------------
    task automatic do_cmd(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input int waits, input bit stall, input int hold,
                          output logic [31:0] r_rdata, output bit r_err, output bit r_to,
                          output int lat, output int acc);
        bit ok, done, rdy;
        int rcyc;
        r_rdata = 0; r_err = 0; r_to = 0; lat = -1; acc = 0;
        cfg_waits = waits;
        cfg_stall = stall;
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_addr = addr; bus.cmd_write = wr; bus.cmd_wdata = wdata;
        bus.rsp_ready = 0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_bound", 64'h0, 64'h1);
            bus.cmd_valid = 0;
            return;
        end
        @(posedge clk);
        done = 0; rcyc = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (bus.PSEL && bus.PENABLE) acc++;
            if (bus.rsp_valid) begin
                if (lat < 0) lat = c;
                rcyc++;
                rdy = (hold < 0) ? 1'($urandom) : (rcyc > hold);
            end else begin
                rdy = 1'($urandom);
            end
            bus.rsp_ready = rdy;
            if (rdy && bus.rsp_valid) begin
                bus.cmd_valid = 0;
                r_rdata = bus.rsp_rdata; r_err = bus.rsp_err; r_to = bus.rsp_timeout;
                done = 1;
            end else begin
                bus.cmd_valid = 1'($urandom); bus.cmd_addr = $urandom;
                bus.cmd_write = 1'($urandom); bus.cmd_wdata = $urandom;
            end
            @(posedge clk);
        end
        if (!done) chk("response_bound", 64'h0, 64'h1);
        $display("txn addr=%0d wr=%0d wdata=%h waits=%0d stall=%0d -> rdata=%h err=%0d to=%0d lat=%0d acc=%0d",
                 addr, wr, wdata, waits, stall, r_rdata, r_err, r_to, lat, acc);
    endtask

    initial begin
        logic [31:0] rd;
        bit er, to;
        int lat, acc;
        bus.cmd_valid = 0; bus.cmd_addr = 0; bus.cmd_write = 0; bus.cmd_wdata = 0;
        bus.rsp_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Write, zero-wait slave
        do_cmd(32'd5, 1, 32'hDEADBEEF, 0, 0, 0, rd, er, to, lat, acc);
        chk("wr_latency", lat, 3); chk("wr_access_cycles", acc, 1);
        chk("wr_rdata", rd, 0);    chk("wr_err", er, 0);
        // Read back
        do_cmd(32'd5, 0, 32'h12345678, 0, 0, 0, rd, er, to, lat, acc);
        chk("rd_rdata", rd, 32'hDEADBEEF); chk("rd_err", er, 0);
        // Slave error
        do_cmd(32'd40, 0, 32'h0, 0, 0, 0, rd, er, to, lat, acc);
        chk("slverr_err", er, 1); chk("slverr_timeout", to, 0);
        // Timeout with stalled slave
        do_cmd(32'd7, 1, 32'hCAFEF00D, 0, 1, 0, rd, er, to, lat, acc);
        chk("to_access_cycles", acc, 4); chk("to_err", er, 1);
        chk("to_timeout", to, 1);        chk("to_latency", lat, 6);
        // PREADY on the timeout edge: normal completion
        do_cmd(32'd7, 0, 32'h0, TO - 1, 0, 0, rd, er, to, lat, acc);
        chk("edge_access_cycles", acc, 4); chk("edge_timeout", to, 0);
        chk("edge_rdata", rd, 0);
        // Backpressure
        do_cmd(32'd5, 0, 32'h0, 1, 0, 10, rd, er, to, lat, acc);
        chk("bp_rdata", rd, 32'hDEADBEEF); chk("bp_latency", lat, 4);

        // Reset in ACCESS with the slave stalled
        cfg_stall = 1;
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_addr = 32'd9; bus.cmd_write = 1; bus.cmd_wdata = 32'h55AA55AA;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk); bus.cmd_valid = 0;
        repeat (2) @(negedge clk);
        chk("pre_reset_in_access", {62'h0, bus.PSEL, bus.PENABLE}, 64'h3);
        rst_n = 0;
        @(negedge clk);
        chk("reset_psel", bus.PSEL, 0); chk("reset_rsp_valid", bus.rsp_valid, 0);
        rst_n = 1;
        $display("txn reset mid-access applied");
        do_cmd(32'd9, 0, 32'h0, 0, 0, 0, rd, er, to, lat, acc);
        chk("post_reset_rdata", rd, 0); chk("post_reset_err", er, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            do_cmd($urandom_range(0, 39), 1'($urandom), $urandom, $urandom_range(0, 5),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, 3),
                   rd, er, to, lat, acc);
        end
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Upstream APB requester for the APB RAM slave. It takes one command at a time on a valid/ready request interface and runs the APB SETUP and ACCESS phases. It then returns read data and error status on a valid/ready response interface. A programmable wait-state timeout stops a slave that never asserts PREADY from hanging the bus.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr and PADDR
DATA_WIDTH, 32, width of the data buses
TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before forced termination; 0 disables the timeout

Ports:
PCLK  in  1  sole clock, rising edge
PRESETn  in  1  synchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_write  in  1  1 = write, 0 = read
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer ended by timeout
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Clock and reset: single clock PCLK; reset PRESETn is synchronous and active-low.
- Reset values: when PRESETn is sampled low, every output goes to 0 at that edge and the state goes to IDLE. This covers cmd_ready, rsp_*, PADDR, PSEL, PENABLE, PWRITE and PWDATA.
- All outputs are registered.
- States are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid&&cmd_ready at an edge, latch addr/write/wdata into PADDR/PWRITE/PWDATA, then go to SETUP.
  - PWDATA is forced to 0 for reads.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0.
  - Go to ACCESS and clear the wait counter.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS.
  - At each edge with PREADY=1:
    - capture rsp_rdata = PWRITE ? 0 : PRDATA;
    - rsp_err = PSLVERR, rsp_timeout = 0;
    - drive PSEL=0 and PENABLE=0;
    - go to RESP.
  - At each edge with PREADY=0, increment the wait counter.
  - Timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0:
    - rsp_rdata=0, rsp_err=1, rsp_timeout=1;
    - drive PSEL=0 and PENABLE=0;
    - go to RESP.
  - PREADY at the same edge as the timeout wins: normal completion.
- RESP:
  - rsp_valid=1; rsp_* are held stable until the handshake.
  - On rsp_ready, go to IDLE with rsp_valid=0 at the next cycle.
  - cmd_ready becomes 1 in that IDLE cycle.
- Latency:
  - Zero-wait-state slave: accept edge → SETUP → ACCESS → RESP, so rsp_valid rises 3 cycles after acceptance.
  - Each slave wait state adds 1 cycle.
- Throughput: one outstanding transfer; minimum 4 cycles per command when rsp_ready is held high.
- Bus idle:
  - PSEL=0 in IDLE and RESP.
  - PADDR/PWRITE/PWDATA hold their last values in IDLE and RESP.
- Handshake inputs: cmd_* are ignored outside IDLE; rsp_ready is ignored outside RESP.
- Reset mid-transfer:
  - bus is released at the reset edge;
  - no response is emitted;
  - the pending command is dropped.
- Address: passed through unmodified; range checking belongs to the slave.
- Wait counter: width $clog2(TIMEOUT_CYCLES+1), saturating, cleared on entry to SETUP.

Decomposition:
- Shared package apb_pkg:
  - apb_master_state_t enum {IDLE, SETUP, ACCESS, RESP};
  - default ADDR/DATA width localparams, shared with the APB RAM slave.
- One sub-module, apb_timeout_counter:
  - inputs: clear, enable;
  - parameter TIMEOUT_CYCLES;
  - output: expired.
- FSM and datapath registers stay in apb_master_bridge.

Test Plan:
- Write, zero-wait slave: cmd addr=5, wdata=0xDEADBEEF, write=1 → one SETUP cycle then one ACCESS cycle with PADDR=5 and PWDATA=0xDEADBEEF; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read back: addr=5, write=1 then write=0 → rsp_rdata=0xDEADBEEF, rsp_err=0; PWDATA=0 during the read.
- Slave error: addr=40, so the slave returns PSLVERR=1 with PREADY → rsp_err=1, rsp_timeout=0; bus released the next cycle.
- Timeout: TIMEOUT_CYCLES=4, PREADY tied 0 → ACCESS lasts exactly 4 cycles; then rsp_err=1, rsp_timeout=1, PSEL=0.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_valid and rsp_rdata stable, cmd_ready=0 throughout, PSEL=0; completes on rsp_ready=1.
- Reset in ACCESS with the slave stalled: PRESETn=0 for one edge → all outputs 0, no rsp_valid; a subsequent command completes normally.
